poly_pointwise_engine: RTL
==========================

Name: poly_pointwise_engine

Overview:
Parametrised coefficient-wise polynomial arithmetic engine for the Kyber datapath (q = 3329). It is the successor to the ADDSUB mode of the NTT processor, split out into its own block and generalised in lane count, RAM read latency and operation set. It streams two polynomials from the shared coefficient RAM through a single read port, computes modular ADD/SUB/RSUB/COPY per lane, and writes the result back through a single write port. It sits beside the NTT core on the same RAM bus, under the same start/offset control scheme.

Parameters:
LANES, 8, coefficients per RAM word
COEF_W, 12, bits per coefficient
Q, 3329, modulus
ADDR_W, 8, RAM address width
NWORDS, 32, words per polynomial (256/LANES)
RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle launch pulse, sampled only in IDLE
mode  in  2  0 ADD (A+B), 1 SUB (A-B), 2 RSUB (B-A), 3 COPY (A mod q)
r_start_offset_A  in  ADDR_W  base address of operand A
r_start_offset_B  in  ADDR_W  base address of operand B (ignored in COPY)
w_data_addr_offset  in  ADDR_W  base address of result
r_data  in  LANES*COEF_W  RAM read data; lane k at bits [k*COEF_W +: COEF_W]
r_data_addr  out  ADDR_W  RAM read address
w_data_addr  out  ADDR_W  RAM write address
w_data  out  LANES*COEF_W  RAM write data, same lane packing
w_data_en  out  1  RAM write strobe
busy  out  1  high from the cycle after start through the done cycle
done  out  1  one-cycle completion pulse
last_cycle  out  1  high together with the final w_data_en

Behaviour:
- Reset (asynchronous, rst=0): FSM goes to IDLE. All outputs are 0. Any pending write is discarded. Applies mid-operation too; the next start after rst release runs normally.
- FSM states: IDLE -> RUN (issue read addresses) -> DRAIN (wait for outstanding results) -> DONE (one cycle; done=1) -> IDLE.
- Launch: start=1 in IDLE latches mode and all three offsets. Later changes to these inputs are ignored until the next launch. start outside IDLE is ignored.
- Cycle numbering: the start-sampling edge ends cycle 0.
- Two-operand modes (ADD, SUB, RSUB):
  - Word i: r_data_addr = A+i in cycle 1+2i, then B+i in cycle 2+2i.
  - A data is captured at cycle 1+2i+RD_LAT. The result is registered at the end of cycle 2+2i+RD_LAT.
  - Write occurs in cycle 3+2i+RD_LAT with w_data_addr = W+i.
- COPY mode: r_data_addr = A+i in cycle 1+i; write in cycle 2+i+RD_LAT.
- With defaults (NWORDS=32, RD_LAT=1), two-operand mode:
  - Last write in cycle 66, with last_cycle=1 in cycle 66.
  - done=1 in cycle 67; busy falls in cycle 68.
- With defaults, COPY: last write in cycle 34, done in cycle 35.
- r_data_addr holds its last value when not reading. w_data_en is 0 outside write cycles.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is legal.
- In-place operation (W==A or W==B) is supported, because word i is always read before it is written. Partially overlapping regions are undefined.
- Arithmetic per lane, with a, b in [0,Q):
  - ADD: s = a+b (COEF_W+1 bits); out = s>=Q ? s-Q : s.
  - SUB: d = a-b; out = d<0 ? d+Q : d. RSUB: the same with a and b swapped.
  - COPY: accepts any a < 2^COEF_W (below 2Q); out = a>=Q ? a-Q : a.
- Outputs are always in [0,Q) for legal inputs. ADD/SUB with inputs >= Q yield the low COEF_W bits of the above arithmetic; this is not an error condition.
- Mode values are fully decoded; there is no illegal mode.

Decomposition:
- Shared package (kyber_pkg): Q, COEF_W, mode encodings (MODE_ADD/SUB/RSUB/COPY), FSM state encodings.
- Sub-module mod_addsub_lane: combinational, ports a, b, mode, out. Instantiated LANES times by generate.
- The top level holds the FSM, word counter, read-phase toggle, RD_LAT-deep valid/phase shift register, A-operand register, result register and write-address counter.

Test Plan:
- ADD, defaults, lane0 A=3000 B=400, lane1 A=0 B=0, A=0/B=64/W=128 -> lane0 writes 71, lane1 writes 0; writes at W+0..W+31 in cycles 4,6,…,66; last_cycle in 66; done in 67.
- SUB with A=5 B=10 -> 3324; RSUB with the same data -> 5; A=B=3328 under SUB -> 0.
- COPY with lanes 4000, 3329, 3328, 0 -> 671, 0, 3328, 0; 32 writes in cycles 3..34; B never read.
- Wrap-around: A=240, W=240 (in-place), ADD, B=0 -> reads 240..255 then 0..15; results overwrite the same addresses correctly.
- Robustness: start pulsed again mid-run -> ignored, exactly 32 writes. rst=0 in cycle 20 -> all outputs 0 immediately, no further writes; a new start then completes normally.
- Parameter sweep: LANES=4, NWORDS=64, RD_LAT=2, ADD -> first write cycle 5, last write cycle 131, done 132; random vectors match a reference model (a op b) mod 3329.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants and encodings for the Kyber coefficient datapath blocks.
package kyber_pkg;

  localparam int KYBER_Q      = 3329;
  localparam int KYBER_COEF_W = 12;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_RSUB = 2'd2,
    MODE_COPY = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mod_addsub_lane.sv
// One coefficient lane: modular add, subtract, reverse subtract or reduce-copy.
module mod_addsub_lane
  import kyber_pkg::*;
#(
  parameter int COEF_W = KYBER_COEF_W,
  parameter int Q      = KYBER_Q
) (
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  mode_e             mode,
  output logic [COEF_W-1:0] out
);

  localparam logic [COEF_W:0] QX = (COEF_W+1)'(Q);

  logic [COEF_W:0] aX, bX, sum, diff, rdiff;

  // One extra bit so the sum and the borrow of each difference stay visible.
  always_comb begin
    aX    = {1'b0, a};
    bX    = {1'b0, b};
    sum   = aX + bX;
    diff  = aX - bX;
    rdiff = bX - aX;
    out   = a;
    case (mode)
      MODE_ADD:  out = (sum >= QX) ? COEF_W'(sum - QX) : sum[COEF_W-1:0];
      MODE_SUB:  out = (a < b) ? COEF_W'(diff + QX) : diff[COEF_W-1:0];
      MODE_RSUB: out = (b < a) ? COEF_W'(rdiff + QX) : rdiff[COEF_W-1:0];
      default:   out = (aX >= QX) ? COEF_W'(aX - QX) : a;
    endcase
  end

endmodule

// File: rtl/poly_pointwise_engine.sv
// Streams two polynomials from the coefficient RAM through one read port,
// applies a per-lane modular operation and writes the result back.
module poly_pointwise_engine
  import kyber_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int COEF_W = KYBER_COEF_W,
  parameter int Q      = KYBER_Q,
  parameter int ADDR_W = 8,
  parameter int NWORDS = 32,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_W-1:0]       r_start_offset_A,
  input  logic [ADDR_W-1:0]       r_start_offset_B,
  input  logic [ADDR_W-1:0]       w_data_addr_offset,
  input  logic [LANES*COEF_W-1:0] r_data,
  output logic [ADDR_W-1:0]       r_data_addr,
  output logic [ADDR_W-1:0]       w_data_addr,
  output logic [LANES*COEF_W-1:0] w_data,
  output logic                    w_data_en,
  output logic                    busy,
  output logic                    done,
  output logic                    last_cycle
);

  localparam int DW    = LANES * COEF_W;
  localparam int CNT_W = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] rAddr_q, rAddr_d, aPtr_q, aPtr_d, bPtr_q, bPtr_d;
  logic [ADDR_W-1:0] wPtr_q, wAddr_q;
  logic [CNT_W-1:0]  rdWord_q, rdWord_d, wCnt_q;
  logic              rdValid_q, rdValid_d, rdPhase_q, rdPhase_d;
  logic [RD_LAT-1:0] pipeV_q, pipeP_q;
  logic [DW-1:0]     aReg_q, res_q, laneA, laneOut;
  logic              wen_q, lastW_q;
  logic              launch, twoOp, dataV, dataP;

  assign launch = (state_q == ST_IDLE) && start;
  assign twoOp  = (mode_q != MODE_COPY);
  assign dataV  = pipeV_q[RD_LAT-1];
  assign dataP  = pipeP_q[RD_LAT-1];
  assign laneA  = twoOp ? aReg_q : r_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod_addsub_lane #(.COEF_W(COEF_W), .Q(Q)) u_lane (
      .a    (laneA[k*COEF_W +: COEF_W]),
      .b    (r_data[k*COEF_W +: COEF_W]),
      .mode (mode_q),
      .out  (laneOut[k*COEF_W +: COEF_W])
    );
  end

  // Read sequencer: two-operand modes alternate A/B per word, COPY reads A only.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rAddr_d   = rAddr_q;
    aPtr_d    = aPtr_q;
    bPtr_d    = bPtr_q;
    rdWord_d  = rdWord_q;
    rdPhase_d = rdPhase_q;
    rdValid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(mode);
          rAddr_d   = r_start_offset_A;
          aPtr_d    = r_start_offset_A + ADDR_W'(1);
          bPtr_d    = r_start_offset_B;
          rdWord_d  = '0;
          rdPhase_d = 1'b0;
          rdValid_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (twoOp && !rdPhase_q) begin
          rAddr_d   = bPtr_q;
          bPtr_d    = bPtr_q + ADDR_W'(1);
          rdPhase_d = 1'b1;
          rdValid_d = 1'b1;
        end else if (rdWord_q == LAST_WORD) begin
          state_d = ST_DRAIN;
        end else begin
          rAddr_d   = aPtr_q;
          aPtr_d    = aPtr_q + ADDR_W'(1);
          rdWord_d  = rdWord_q + CNT_W'(1);
          rdPhase_d = 1'b0;
          rdValid_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wen_q && lastW_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ADD;
      rAddr_q   <= '0;
      aPtr_q    <= '0;
      bPtr_q    <= '0;
      rdWord_q  <= '0;
      rdPhase_q <= 1'b0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rAddr_q   <= rAddr_d;
      aPtr_q    <= aPtr_d;
      bPtr_q    <= bPtr_d;
      rdWord_q  <= rdWord_d;
      rdPhase_q <= rdPhase_d;
      rdValid_q <= rdValid_d;
    end
  end

  // Valid/phase tags follow each read through the RAM latency to meet its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipeV_q <= '0;
      pipeP_q <= '0;
      aReg_q  <= '0;
      res_q   <= '0;
      wen_q   <= 1'b0;
      lastW_q <= 1'b0;
      wPtr_q  <= '0;
      wAddr_q <= '0;
      wCnt_q  <= '0;
    end else begin
      pipeV_q <= RD_LAT'({pipeV_q, rdValid_q});
      pipeP_q <= RD_LAT'({pipeP_q, rdPhase_q});
      wen_q   <= 1'b0;
      lastW_q <= 1'b0;
      if (launch) begin
        wPtr_q <= w_data_addr_offset;
        wCnt_q <= '0;
      end else if (dataV) begin
        if (twoOp && !dataP) begin
          aReg_q <= r_data;
        end else begin
          res_q   <= laneOut;
          wen_q   <= 1'b1;
          lastW_q <= (wCnt_q == LAST_WORD);
          wAddr_q <= wPtr_q;
          wPtr_q  <= wPtr_q + ADDR_W'(1);
          wCnt_q  <= wCnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign r_data_addr = rAddr_q;
  assign w_data_addr = wAddr_q;
  assign w_data      = res_q;
  assign w_data_en   = wen_q;
  assign last_cycle  = wen_q && lastW_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule
